// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM states, the debug
// hazard-cause encoding and the bundle of pipeline control outputs.
package hazard_pkg;

  typedef enum logic {
    HZ_RUN    = 1'b0,
    HZ_FREEZE = 1'b1
  } hz_state_t;

  localparam int unsigned REG_ZERO = 0;

  typedef enum logic [2:0] {
    CAUSE_NONE     = 3'd0,
    CAUSE_LOAD_USE = 3'd1,
    CAUSE_BR_EX    = 3'd2,
    CAUSE_BR_MEM   = 3'd3,
    CAUSE_FLUSH    = 3'd4,
    CAUSE_FREEZE   = 3'd5
  } hz_cause_t;

  typedef struct packed {
    logic pc_stall;
    logic if_id_stall;
    logic id_ex_bubble;
    logic if_id_flush;
    logic pipe_freeze;
  } hz_ctrl_t;

  // Single place that defines what each winning cause does to the pipeline.
  function automatic hz_ctrl_t cause_to_ctrl(input hz_cause_t cause);
    hz_ctrl_t ctrl;
    ctrl = '0;
    case (cause)
      CAUSE_FREEZE: begin
        ctrl.pc_stall    = 1'b1;
        ctrl.if_id_stall = 1'b1;
        ctrl.pipe_freeze = 1'b1;
      end
      CAUSE_LOAD_USE, CAUSE_BR_EX, CAUSE_BR_MEM: begin
        ctrl.pc_stall     = 1'b1;
        ctrl.if_id_stall  = 1'b1;
        ctrl.id_ex_bubble = 1'b1;
      end
      CAUSE_FLUSH: ctrl.if_id_flush = 1'b1;
      default:     ctrl = '0;
    endcase
    return ctrl;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Register dependency comparator: does a producer destination feed an operand
// actually read by the instruction in ID, optionally ignoring register 0.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter bit ZERO_REG_FILTER = 1'b1
) (
  input  logic [REG_AW-1:0] dst,
  input  logic [REG_AW-1:0] rs,
  input  logic [REG_AW-1:0] rt,
  input  logic              use_rs,
  input  logic              use_rt,
  output logic              hit
);

  logic raw_hit;

  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch.
  always_comb begin
    // The use flag gates each compare so an unused (possibly X) field is inert.
    raw_hit = ((dst == rs) && use_rs) || ((dst == rt) && use_rt);
    hit     = raw_hit;
    if (ZERO_REG_FILTER && (dst == REG_AW'(REG_ZERO))) begin
      hit = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_ctrl_unit.sv
// Prioritised hazard controller for the 5-stage core: memory freeze, load-use
// and branch-in-ID stalls, taken-branch flush, plus saturating event counters.
module hazard_ctrl_unit
  import hazard_pkg::*;
#(
  parameter int REG_AW          = 5,
  parameter int CNT_W           = 16,
  parameter bit BRANCH_IN_ID    = 1'b1,
  parameter bit ZERO_REG_FILTER = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [REG_AW-1:0] if_id_rs,
  input  logic [REG_AW-1:0] if_id_rt,
  input  logic              if_id_use_rs,
  input  logic              if_id_use_rt,
  input  logic              id_branch,
  input  logic              id_branch_taken,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic [REG_AW-1:0] id_ex_dst,
  input  logic              ex_mem_mem_read,
  input  logic [REG_AW-1:0] ex_mem_dst,
  input  logic              mem_req,
  input  logic              mem_ready,
  output logic              pc_stall,
  output logic              if_id_stall,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic              pipe_freeze,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  freeze_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic      hit_lu, hit_bex, hit_bmem;
  logic      h_lu, h_bex, h_bmem;
  logic      freeze;
  hz_state_t state_q, state_d;
  hz_cause_t cause;
  hz_ctrl_t  ctrl;

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] freeze_cnt_q, freeze_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  hazard_match #(.REG_AW(REG_AW), .ZERO_REG_FILTER(ZERO_REG_FILTER)) u_match_lu (
    .dst    (id_ex_dst),
    .rs     (if_id_rs),
    .rt     (if_id_rt),
    .use_rs (if_id_use_rs),
    .use_rt (if_id_use_rt),
    .hit    (hit_lu)
  );

  hazard_match #(.REG_AW(REG_AW), .ZERO_REG_FILTER(ZERO_REG_FILTER)) u_match_bex (
    .dst    (id_ex_dst),
    .rs     (if_id_rs),
    .rt     (if_id_rt),
    .use_rs (if_id_use_rs),
    .use_rt (if_id_use_rt),
    .hit    (hit_bex)
  );

  hazard_match #(.REG_AW(REG_AW), .ZERO_REG_FILTER(ZERO_REG_FILTER)) u_match_bmem (
    .dst    (ex_mem_dst),
    .rs     (if_id_rs),
    .rt     (if_id_rt),
    .use_rs (if_id_use_rs),
    .use_rt (if_id_use_rt),
    .hit    (hit_bmem)
  );

  assign h_lu   = id_ex_mem_read && hit_lu;
  assign h_bex  = BRANCH_IN_ID && id_branch && id_ex_reg_write && hit_bex;
  assign h_bmem = BRANCH_IN_ID && id_branch && ex_mem_mem_read && hit_bmem;

  // Memory-wait FSM. The freeze is Mealy so the request cycle itself holds.
  always_comb begin
    state_d = state_q;
    freeze  = 1'b0;
    case (state_q)
      HZ_RUN: begin
        if (mem_req && !mem_ready) begin
          state_d = HZ_FREEZE;
          freeze  = 1'b1;
        end
      end
      HZ_FREEZE: begin
        if (mem_ready) begin
          state_d = HZ_RUN;
        end else begin
          freeze = 1'b1;
        end
      end
      default: state_d = HZ_RUN;
    endcase
  end

  // Priority select; reset forces every control low regardless of inputs.
  always_comb begin
    cause = CAUSE_NONE;
    if (!rst_n) begin
      cause = CAUSE_NONE;
    end else if (freeze) begin
      cause = CAUSE_FREEZE;
    end else if (h_lu) begin
      cause = CAUSE_LOAD_USE;
    end else if (h_bex) begin
      cause = CAUSE_BR_EX;
    end else if (h_bmem) begin
      cause = CAUSE_BR_MEM;
    end else if (id_branch && id_branch_taken) begin
      cause = CAUSE_FLUSH;
    end
  end

  assign ctrl         = cause_to_ctrl(cause);
  assign pc_stall     = ctrl.pc_stall;
  assign if_id_stall  = ctrl.if_id_stall;
  assign id_ex_bubble = ctrl.id_ex_bubble;
  assign if_id_flush  = ctrl.if_id_flush;
  assign pipe_freeze  = ctrl.pipe_freeze;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value,
                                               input logic            en);
    return (en && (value != '1)) ? value + CNT_W'(1) : value;
  endfunction

  always_comb begin
    stall_cnt_d  = sat_inc(stall_cnt_q, ctrl.id_ex_bubble);
    freeze_cnt_d = sat_inc(freeze_cnt_q, ctrl.pipe_freeze);
    flush_cnt_d  = sat_inc(flush_cnt_q, ctrl.if_id_flush);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; only the FSM and the counters carry state here, and all of
  // them are reset because software reads the counters directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= HZ_RUN;
      stall_cnt_q  <= '0;
      freeze_cnt_q <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      freeze_cnt_q <= freeze_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign freeze_cnt = freeze_cnt_q;
  assign flush_cnt  = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: four parameter variants share one
// stimulus stream; expectations are queued and checked at each falling edge.
module tb_hazard_ctrl_unit;

  localparam int AW = 5;
  // Variant index: 0 default, 1 no zero filter, 2 no branch-in-ID, 3 CNT_W=2.
  localparam int NDUT = 4;

  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b11100;
  localparam logic [4:0] C_FLUSH = 5'b00010;
  localparam logic [4:0] C_FRZ   = 5'b11001;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [AW-1:0] if_id_rs, if_id_rt, id_ex_dst, ex_mem_dst;
  logic          if_id_use_rs, if_id_use_rt, id_branch, id_branch_taken;
  logic          id_ex_mem_read, id_ex_reg_write, ex_mem_mem_read;
  logic          mem_req, mem_ready;

  wire [4:0]  ctl_w [NDUT];
  wire [15:0] st_w  [NDUT];
  wire [15:0] fz_w  [NDUT];
  wire [15:0] fl_w  [NDUT];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int CW = (g == 3) ? 2 : 16;
    wire          pcs, ifs, bub, fls, frz;
    wire [CW-1:0] sc, fc, lc;

    hazard_ctrl_unit #(
      .REG_AW          (AW),
      .CNT_W           (CW),
      .BRANCH_IN_ID    (g != 2),
      .ZERO_REG_FILTER (g != 1)
    ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .if_id_rs        (if_id_rs),
      .if_id_rt        (if_id_rt),
      .if_id_use_rs    (if_id_use_rs),
      .if_id_use_rt    (if_id_use_rt),
      .id_branch       (id_branch),
      .id_branch_taken (id_branch_taken),
      .id_ex_mem_read  (id_ex_mem_read),
      .id_ex_reg_write (id_ex_reg_write),
      .id_ex_dst       (id_ex_dst),
      .ex_mem_mem_read (ex_mem_mem_read),
      .ex_mem_dst      (ex_mem_dst),
      .mem_req         (mem_req),
      .mem_ready       (mem_ready),
      .pc_stall        (pcs),
      .if_id_stall     (ifs),
      .id_ex_bubble    (bub),
      .if_id_flush     (fls),
      .pipe_freeze     (frz),
      .stall_cnt       (sc),
      .freeze_cnt      (fc),
      .flush_cnt       (lc)
    );

    assign ctl_w[g] = {pcs, ifs, bub, fls, frz};
    assign st_w[g]  = 16'(sc);
    assign fz_w[g]  = 16'(fc);
    assign fl_w[g]  = 16'(lc);
  end

  typedef struct {
    string      name;
    int         sel;
    bit         is_cnt;
    logic [4:0] ctrl;
    int         s;
    int         f;
    int         l;
  } exp_t;

  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic exp_ctrl(input int sel, input logic [4:0] c, input string name);
    exp_t e;
    e.name = name; e.sel = sel; e.is_cnt = 1'b0; e.ctrl = c;
    e.s = 0; e.f = 0; e.l = 0;
    sb_q.push_back(e);
  endtask

  task automatic exp_cnt(input int sel, input int s, input int f, input int l, input string name);
    exp_t e;
    e.name = name; e.sel = sel; e.is_cnt = 1'b1; e.ctrl = C_NONE;
    e.s = s; e.f = f; e.l = l;
    sb_q.push_back(e);
  endtask

  // Monitor: outputs are stable at the falling edge; drain every pending entry.
  always @(negedge clk) begin
    while (sb_q.size() != 0) begin
      exp_t e;
      e = sb_q.pop_front();
      if (e.is_cnt) begin
        check({e.name, "_stall_cnt"},  32'(st_w[e.sel]), 32'(e.s));
        check({e.name, "_freeze_cnt"}, 32'(fz_w[e.sel]), 32'(e.f));
        check({e.name, "_flush_cnt"},  32'(fl_w[e.sel]), 32'(e.l));
      end else begin
        check({e.name, "_ctrl"}, 32'(ctl_w[e.sel]), 32'(e.ctrl));
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    if_id_rs = '0; if_id_rt = '0; id_ex_dst = '0; ex_mem_dst = '0;
    if_id_use_rs = 1'b0; if_id_use_rt = 1'b0;
    id_branch = 1'b0; id_branch_taken = 1'b0;
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; ex_mem_mem_read = 1'b0;
    mem_req = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic set_lu(input logic [AW-1:0] r);
    id_ex_mem_read = 1'b1; id_ex_dst = r; if_id_rs = r; if_id_use_rs = 1'b1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    clear_in();
    @(posedge clk);
    #1;

    // Reset held: hazards, memory wait and taken branch all present, outputs 0.
    set_lu(5'd8); mem_req = 1'b1; id_branch = 1'b1; id_branch_taken = 1'b1;
    exp_ctrl(0, C_NONE, "rst_hold"); exp_cnt(0, 0, 0, 0, "rst_hold");
    exp_ctrl(3, C_NONE, "rst_hold_c2"); exp_cnt(3, 0, 0, 0, "rst_hold_c2");
    next_cycle();

    rst_n = 1'b1; clear_in();
    exp_ctrl(0, C_NONE, "post_rst"); exp_cnt(0, 0, 0, 0, "post_rst");
    next_cycle();

    // Saturation of a 2-bit counter across five bubble cycles.
    set_lu(5'd8);
    for (int k = 0; k < 5; k++) begin
      exp_ctrl(0, C_STALL, "sat_stall");
      exp_cnt(3, (k > 3) ? 3 : k, 0, 0, "sat_c2");
      next_cycle();
    end
    clear_in();
    exp_cnt(3, 3, 0, 0, "sat_hold_c2"); exp_cnt(0, 5, 0, 0, "sat_wide");
    next_cycle();

    // Reset in the middle of a memory wait.
    mem_req = 1'b1; mem_ready = 1'b0;
    exp_ctrl(0, C_FRZ, "frz_enter");
    next_cycle();
    exp_ctrl(0, C_FRZ, "frz_hold"); exp_cnt(0, 5, 1, 0, "frz_hold");
    next_cycle();
    rst_n = 1'b0;
    exp_ctrl(0, C_NONE, "rst_in_frz"); exp_cnt(0, 0, 0, 0, "rst_in_frz");
    exp_cnt(3, 0, 0, 0, "rst_in_frz_c2");
    next_cycle();
    rst_n = 1'b1; mem_req = 1'b0;
    exp_ctrl(0, C_NONE, "rst_rel_run"); exp_cnt(0, 0, 0, 0, "rst_rel_run");
    next_cycle();
    mem_req = 1'b1; mem_ready = 1'b1;
    exp_ctrl(0, C_NONE, "req_ready_same");
    next_cycle();

    // Load-use via rs, rt, unused operands, and X on an unused field.
    clear_in(); set_lu(5'd8);
    exp_ctrl(0, C_STALL, "lu_rs"); exp_cnt(0, 0, 0, 0, "lu_rs");
    next_cycle();
    clear_in();
    exp_ctrl(0, C_NONE, "lu_done"); exp_cnt(0, 1, 0, 0, "lu_done");
    next_cycle();
    id_ex_mem_read = 1'b1; id_ex_dst = 5'd9; if_id_rs = 5'd9; if_id_rt = 5'd9; if_id_use_rt = 1'b1;
    exp_ctrl(0, C_STALL, "lu_rt");
    next_cycle();
    if_id_use_rt = 1'b0;
    exp_ctrl(0, C_NONE, "lu_unused");
    next_cycle();
    if_id_rs = 'x; id_ex_dst = 5'd5; if_id_rt = 5'd5; if_id_use_rt = 1'b1;
    exp_ctrl(0, C_STALL, "lu_x_safe");
    next_cycle();
    if_id_rs = '0; id_ex_mem_read = 1'b0;
    exp_ctrl(0, C_NONE, "no_load"); exp_cnt(0, 3, 0, 0, "no_load");
    next_cycle();

    // lw $8 ; beq $8,$9 : two stall cycles then the flush.
    clear_in(); set_lu(5'd8); id_ex_reg_write = 1'b1;
    if_id_rt = 5'd9; if_id_use_rt = 1'b1; id_branch = 1'b1; id_branch_taken = 1'b1;
    exp_ctrl(0, C_STALL, "lwbeq_c1");
    next_cycle();
    id_ex_mem_read = 1'b0; id_ex_reg_write = 1'b0; ex_mem_mem_read = 1'b1; ex_mem_dst = 5'd8;
    exp_ctrl(0, C_STALL, "lwbeq_c2"); exp_ctrl(2, C_FLUSH, "lwbeq_c2_nobr");
    next_cycle();
    ex_mem_mem_read = 1'b0;
    exp_ctrl(0, C_FLUSH, "lwbeq_c3"); exp_cnt(0, 5, 0, 0, "lwbeq_c3");
    next_cycle();
    clear_in();
    exp_ctrl(0, C_NONE, "lwbeq_done"); exp_cnt(0, 5, 0, 1, "lwbeq_done");
    next_cycle();

    // ALU producer then taken beq: stall wins over flush; without BRANCH_IN_ID flush.
    id_ex_reg_write = 1'b1; id_ex_dst = 5'd9; if_id_rs = 5'd8; if_id_use_rs = 1'b1;
    if_id_rt = 5'd9; if_id_use_rt = 1'b1; id_branch = 1'b1; id_branch_taken = 1'b1;
    exp_ctrl(0, C_STALL, "bex_prio"); exp_ctrl(2, C_FLUSH, "bex_nobr");
    next_cycle();
    id_ex_reg_write = 1'b0; id_branch_taken = 1'b0;
    exp_ctrl(0, C_NONE, "br_not_taken");
    next_cycle();
    id_ex_reg_write = 1'b1; id_branch = 1'b0;
    exp_ctrl(0, C_NONE, "alu_no_branch"); exp_cnt(0, 6, 0, 1, "alu_no_branch");
    next_cycle();

    // Register 0 never creates a dependency when filtered.
    clear_in(); set_lu(5'd0);
    exp_ctrl(0, C_NONE, "zero_lu_filt"); exp_ctrl(1, C_STALL, "zero_lu_nofilt");
    next_cycle();
    clear_in(); ex_mem_mem_read = 1'b1; ex_mem_dst = 5'd0; if_id_use_rs = 1'b1; id_branch = 1'b1;
    exp_ctrl(0, C_NONE, "zero_bmem_filt"); exp_ctrl(1, C_STALL, "zero_bmem_nofilt");
    next_cycle();

    // Three-cycle memory wait with a coincident load-use held back.
    clear_in(); set_lu(5'd8); mem_req = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exp_ctrl(0, C_FRZ, "mem_wait");
      exp_cnt(0, 6, k, 1, "mem_wait");
      next_cycle();
    end
    mem_ready = 1'b1;
    exp_ctrl(0, C_STALL, "mem_done_lu"); exp_cnt(0, 6, 3, 1, "mem_done_lu");
    next_cycle();
    clear_in();
    exp_ctrl(0, C_NONE, "mem_idle"); exp_cnt(0, 7, 3, 1, "mem_idle");
    next_cycle();

    // In FREEZE mem_req is ignored and a taken branch cannot flush.
    mem_req = 1'b1;
    exp_ctrl(0, C_FRZ, "frz2_enter");
    next_cycle();
    mem_req = 1'b0; id_branch = 1'b1; id_branch_taken = 1'b1;
    exp_ctrl(0, C_FRZ, "frz2_noreq_br");
    next_cycle();
    id_branch = 1'b0; id_branch_taken = 1'b0; mem_ready = 1'b1;
    exp_ctrl(0, C_NONE, "frz2_ready");
    next_cycle();
    clear_in();
    exp_ctrl(0, C_NONE, "frz2_back_run"); exp_cnt(0, 7, 5, 1, "final");
    next_cycle();

    if (sb_q.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_unit.md
Name: hazard_ctrl_unit

Overview:
Parametrised pipeline hazard controller for the 5-stage MIPS core. It is the successor to the separate data- and control-hazard detectors and combines load-use, branch-in-ID dependency, branch-taken flush and multi-cycle data-memory freeze into one prioritised unit. It sits beside the ID stage and drives the PC, IF/ID, ID/EX and whole-pipeline hold controls. Saturating performance counters are included.

Parameters:
REG_AW, 5, register address width
CNT_W, 16, width of each performance counter
BRANCH_IN_ID, 1, 1: branches resolve in ID and need dependency stalls; 0: branch-dependency checks disabled
ZERO_REG_FILTER, 1, 1: register 0 never causes a hazard

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
if_id_rs  in  REG_AW  rs of the instruction in ID
if_id_rt  in  REG_AW  rt of the instruction in ID
if_id_use_rs  in  1  ID instruction reads rs
if_id_use_rt  in  1  ID instruction reads rt
id_branch  in  1  ID instruction is a conditional branch
id_branch_taken  in  1  branch compare result in ID; valid only when no stall is asserted
id_ex_mem_read  in  1  EX-stage instruction is a load
id_ex_reg_write  in  1  EX-stage instruction writes a register
id_ex_dst  in  REG_AW  EX-stage destination (rt or rd, already muxed)
ex_mem_mem_read  in  1  MEM-stage instruction is a load
ex_mem_dst  in  REG_AW  MEM-stage destination
mem_req  in  1  MEM stage is issuing a data-memory access
mem_ready  in  1  data memory completes the access this cycle
pc_stall  out  1  hold PC
if_id_stall  out  1  hold IF/ID
id_ex_bubble  out  1  zero ID/EX control signals (insert NOP)
if_id_flush  out  1  clear IF/ID to NOP on the next edge
pipe_freeze  out  1  hold every pipeline register, including EX/MEM and MEM/WB
stall_cnt  out  CNT_W  cycles with id_ex_bubble=1
freeze_cnt  out  CNT_W  cycles with pipe_freeze=1
flush_cnt  out  CNT_W  cycles with if_id_flush=1

Behaviour:
- Definitions:
  - match(a) = (a==if_id_rs && if_id_use_rs) || (a==if_id_rt && if_id_use_rt).
  - When ZERO_REG_FILTER=1, match is additionally gated by a!=0.
- Hazard terms, combinational, evaluated every cycle:
  - H_LU = id_ex_mem_read && match(id_ex_dst)
  - H_BEX = BRANCH_IN_ID && id_branch && id_ex_reg_write && match(id_ex_dst)
  - H_BMEM = BRANCH_IN_ID && id_branch && ex_mem_mem_read && match(ex_mem_dst)
  - A load followed directly by a beq therefore stalls 2 cycles: first H_LU/H_BEX, then H_BMEM. An ALU op followed by a beq stalls 1 cycle.
- FSM states:
  - RUN: reset state.
  - FREEZE: memory wait.
- FSM transitions:
  - RUN -> FREEZE when mem_req && !mem_ready. pipe_freeze=1 in that same cycle, i.e. Mealy behaviour, so the pipeline never advances past an unfinished access.
  - FREEZE -> RUN on mem_ready. pipe_freeze=0 in the mem_ready cycle.
  - In FREEZE, pipe_freeze=1 while !mem_ready. mem_req is ignored in FREEZE.
  - A mem_req with mem_ready already high completes in the same cycle and causes no freeze.
- Output priority, one per cycle:
  1. pipe_freeze: pc_stall, if_id_stall and pipe_freeze are all 1; id_ex_bubble=0 and if_id_flush=0 (hazard state is preserved frozen).
  2. H_LU || H_BEX || H_BMEM: pc_stall=if_id_stall=id_ex_bubble=1, if_id_flush=0, and id_branch_taken is ignored.
  3. id_branch && id_branch_taken: if_id_flush=1 and all stalls 0.
  4. Otherwise all outputs are 0.
- All control outputs are combinational, with no added latency.
- Counters:
  - Each counter increments at the posedge when its output is 1 in that cycle.
  - Each counter saturates at 2^CNT_W-1 and never wraps.
- Reset (async, rst_n low):
  - State goes to RUN and all counters go to 0 immediately.
  - While rst_n is low, every control output is 0 regardless of inputs.
  - Reset during FREEZE abandons the wait. On release the FSM starts in RUN and re-evaluates mem_req fresh.
- X-safety: if_id_rs/rt are don't-care when their use flag is 0.

Decomposition:
- Shared package hazard_pkg holds:
  - hz_state_t enum {HZ_RUN, HZ_FREEZE}
  - REG_ZERO constant
  - the hazard-cause encoding {NONE, LOAD_USE, BR_EX, BR_MEM, FLUSH, FREEZE}, for debug
- One natural sub-module, hazard_match, is instantiated three times. It holds the combinational match() with the zero filter.
- The counters are inline; no separate module is needed.

Test Plan:
- Load-use: id_ex_mem_read=1, id_ex_dst=8, if_id_rs=8, use_rs=1 -> pc_stall=if_id_stall=id_ex_bubble=1 for 1 cycle; stall_cnt=1.
- lw $8 then beq $8,$9: cycle1 H_LU stall; cycle2 ex_mem_mem_read=1, ex_mem_dst=8 -> H_BMEM stall; cycle3 id_branch_taken=1 -> if_id_flush=1; stall_cnt=2, flush_cnt=1.
- Zero-register filtering: id_ex_mem_read=1, dst=0, if_id_rs=0 -> no stall with ZERO_REG_FILTER=1; stall with ZERO_REG_FILTER=0.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> pipe_freeze=1 for exactly 3 cycles, FSM returns to RUN, freeze_cnt=3; a coincident H_LU yields no bubble until the freeze ends.
- Priority: H_BEX=1 and id_branch_taken=1 in the same cycle -> stall only, if_id_flush=0. BRANCH_IN_ID=0 with the same stimulus -> flush only.
- Reset/saturation: CNT_W=2, force 5 stall cycles -> stall_cnt holds at 3. Assert rst_n=0 mid-FREEZE -> outputs 0 at once; after release, FSM is in RUN and counters are 0.
